amo_unit: RTL and testbench

Atomic-memory-operation sequencer between the core's data-memory port and the 64-bit data memory bus. Plain loads and stores pass straight through. A-extension requests are expanded into bus transactions:
- LR/SC: a single read or write, with a reservation register.
- AMOSWAP/ADD/XOR/AND/OR/MIN/MAX/MINU/MAXU: a read, an ALU step, then a write.

The block supports RV64 .W and .D forms, with one request in flight at a time.

---
 rtl/eei_pkg.sv | 25 ++
 rtl/amo_alu.sv | 41 ++++
 rtl/amo_unit.sv | 181 ++++++++++++++++++
 tb/tb_amo_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eei_pkg.sv
// Shared execution-environment definitions: machine widths and the A-extension funct5 encodings.
package eei_pkg;

    localparam int XLEN              = 64;
    localparam int MEMBUS_DATA_WIDTH = 64;

    typedef enum logic [4:0] {
        AMO_ADD  = 5'b00000,
        AMO_SWAP = 5'b00001,
        AMO_LR   = 5'b00010,
        AMO_SC   = 5'b00011,
        AMO_XOR  = 5'b00100,
        AMO_OR   = 5'b01000,
        AMO_AND  = 5'b01100,
        AMO_MIN  = 5'b10000,
        AMO_MAX  = 5'b10100,
        AMO_MINU = 5'b11000,
        AMO_MAXU = 5'b11100
    } amo_op_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/amo_alu.sv
// Combinational AMO arithmetic; .W forms operate on the low 32 bits and return a sign-extended result.
module amo_alu
    import eei_pkg::*;
(
    input  amo_op_e          op,
    input  logic             is_word,
    input  logic [XLEN-1:0]  old,
    input  logic [XLEN-1:0]  src,
    output logic [XLEN-1:0]  new_val
);

    logic [XLEN-1:0] a_s, b_s, a_u, b_u, res;
    logic            lt_s, lt_u;

    // Signed views sign-extend and unsigned views zero-extend, so one 64-bit compare serves both widths.
    assign a_s  = is_word ? sext32(old[31:0]) : old;
    assign b_s  = is_word ? sext32(src[31:0]) : src;
    assign a_u  = is_word ? {32'b0, old[31:0]} : old;
    assign b_u  = is_word ? {32'b0, src[31:0]} : src;
    assign lt_s = $signed(a_s) < $signed(b_s);
    assign lt_u = a_u < b_u;

    always_comb begin
        res = a_s;
        case (op)
            AMO_ADD:  res = a_s + b_s;
            AMO_SWAP: res = b_s;
            AMO_XOR:  res = a_s ^ b_s;
            AMO_AND:  res = a_s & b_s;
            AMO_OR:   res = a_s | b_s;
            AMO_MIN:  res = lt_s ? a_s : b_s;
            AMO_MAX:  res = lt_s ? b_s : a_s;
            AMO_MINU: res = lt_u ? a_s : b_s;
            AMO_MAXU: res = lt_u ? b_s : a_s;
            default:  res = a_s;
        endcase
    end

    assign new_val = is_word ? sext32(res[31:0]) : res;

endmodule

// File: rtl/amo_unit.sv
// Sequences A-extension requests into bus read/write transactions; plain loads/stores pass straight through.
// state     | meaning
// S_IDLE    | accepting; plain requests wired through to the bus
// S_PASS    | plain request outstanding, waiting for its bus response
// S_RD      | AMO/LR read request on the bus
// S_WAIT_R  | waiting for read data
// S_WR      | AMO/SC write request on the bus
// S_WAIT_W  | waiting for write acknowledge
// S_SC_FAIL | SC without reservation, respond 1 without bus access
module amo_unit
    import eei_pkg::*;
#(
    parameter int DATA_WIDTH = MEMBUS_DATA_WIDTH,
    parameter int ADDR_WIDTH = XLEN
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    output logic                    s_ready,
    input  logic [ADDR_WIDTH-1:0]   s_addr,
    input  logic                    s_wen,
    input  logic [DATA_WIDTH-1:0]   s_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_wmask,
    input  logic                    s_is_amo,
    input  logic [4:0]              s_amoop,
    input  logic [2:0]              s_funct3,
    output logic                    s_rvalid,
    output logic [DATA_WIDTH-1:0]   s_rdata,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic                    m_wen,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wmask,
    input  logic                    m_rvalid,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_PASS, S_RD, S_WAIT_R, S_WR, S_WAIT_W, S_SC_FAIL
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:2]   addr_q;
    logic [DATA_WIDTH-1:0]   old_q, new_q;
    amo_op_e                 op_q;
    logic                    word_q;
    logic                    resv_valid_q;
    logic [ADDR_WIDTH-1:3]   resv_addr_q;

    amo_op_e                 s_op;
    logic                    amo_accept, resv_hit_s, resv_hit_q;
    logic [31:0]             lane;
    logic [DATA_WIDTH-1:0]   old_ext;
    logic [XLEN-1:0]         alu_new;

    assign s_op       = amo_op_e'(s_amoop);
    assign amo_accept = (state_q == S_IDLE) && s_valid && s_is_amo;
    assign resv_hit_s = resv_valid_q && (resv_addr_q == s_addr[ADDR_WIDTH-1:3]);
    assign resv_hit_q = resv_valid_q && (resv_addr_q == addr_q[ADDR_WIDTH-1:3]);
    assign lane       = addr_q[2] ? m_rdata[63:32] : m_rdata[31:0];
    assign old_ext    = word_q ? sext32(lane) : m_rdata;

    amo_alu u_alu (
        .op      (op_q),
        .is_word (word_q),
        .old     (old_ext),
        .src     (new_q),
        .new_val (alu_new)
    );

    always_comb begin
        state_d  = state_q;
        s_ready  = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        m_valid  = 1'b0;
        m_addr   = {addr_q[ADDR_WIDTH-1:3], 3'b000};
        m_wen    = 1'b0;
        m_wdata  = word_q ? {new_q[31:0], new_q[31:0]} : new_q;
        m_wmask  = word_q ? {{4{addr_q[2]}}, {4{~addr_q[2]}}} : '1;
        case (state_q)
            S_IDLE: begin
                if (s_is_amo) begin
                    s_ready = 1'b1;
                    if (s_valid) begin
                        if (s_op == AMO_SC) state_d = resv_hit_s ? S_WR : S_SC_FAIL;
                        else                state_d = S_RD;
                    end
                end else begin
                    m_valid = s_valid;
                    m_addr  = s_addr;
                    m_wen   = s_wen;
                    m_wdata = s_wdata;
                    m_wmask = s_wmask;
                    s_ready = m_ready;
                    if (s_valid && m_ready) state_d = S_PASS;
                end
            end
            S_PASS: begin
                s_rvalid = m_rvalid;
                s_rdata  = m_rdata;
                if (m_rvalid) state_d = S_IDLE;
            end
            S_RD: begin
                m_valid = 1'b1;
                if (m_ready) state_d = S_WAIT_R;
            end
            S_WAIT_R: begin
                if (m_rvalid) begin
                    if (op_q == AMO_LR) begin
                        s_rvalid = 1'b1;
                        s_rdata  = old_ext;
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_WR;
                    end
                end
            end
            S_WR: begin
                m_valid = 1'b1;
                m_wen   = 1'b1;
                if (m_ready) state_d = S_WAIT_W;
            end
            S_WAIT_W: begin
                if (m_rvalid) begin
                    s_rvalid = 1'b1;
                    s_rdata  = (op_q == AMO_SC) ? '0 : old_q;
                    state_d  = S_IDLE;
                end
            end
            S_SC_FAIL: begin
                s_rvalid = 1'b1;
                s_rdata  = DATA_WIDTH'(1);
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // new_q doubles as the SC store value, so it is loaded with rs2 at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            old_q   <= '0;
            new_q   <= '0;
            op_q    <= AMO_ADD;
            word_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (amo_accept) begin
                addr_q <= s_addr[ADDR_WIDTH-1:2];
                new_q  <= s_wdata;
                op_q   <= s_op;
                word_q <= (s_funct3 == 3'b010);
            end
            if (state_q == S_WAIT_R && m_rvalid) begin
                old_q <= old_ext;
                new_q <= alu_new;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_valid_q <= 1'b0;
            resv_addr_q  <= '0;
        end else if (state_q == S_WAIT_R && m_rvalid && op_q == AMO_LR) begin
            resv_valid_q <= 1'b1;
            resv_addr_q  <= addr_q[ADDR_WIDTH-1:3];
        end else if (amo_accept && s_op == AMO_SC) begin
            resv_valid_q <= 1'b0;
        end else if (state_q == S_IDLE && s_valid && !s_is_amo && s_wen && m_ready && resv_hit_s) begin
            resv_valid_q <= 1'b0;
        end else if (state_q == S_WR && m_ready && resv_hit_q) begin
            resv_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_amo_unit.sv
// Bench for amo_unit: directed latency/reservation scenarios plus random traffic against a memory-level model.
module tb_amo_unit;
    import eei_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_ready, s_wen, s_is_amo, s_rvalid;
    logic [63:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  s_wmask;
    logic [4:0]  s_amoop;
    logic [2:0]  s_funct3;
    logic        m_valid, m_ready, m_wen, m_rvalid;
    logic [63:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_wmask;

    amo_unit dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wen(s_wen),
        .s_wdata(s_wdata), .s_wmask(s_wmask), .s_is_amo(s_is_amo), .s_amoop(s_amoop),
        .s_funct3(s_funct3), .s_rvalid(s_rvalid), .s_rdata(s_rdata),
        .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wen(m_wen),
        .m_wdata(m_wdata), .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Bus memory and monitor state
    logic [63:0] mem [8];
    int          lat = 1;
    bit          rand_ready = 1'b0;
    int          due_q [$];
    logic [63:0] dat_q [$];
    int          cyc = 0;
    int          acc_count = 0, acc_cyc = 0, rv_count = 0, rv_cyc = 0, mv_count = 0;
    logic [63:0] rv_data, last_wdata;
    logic [7:0]  last_wmask;
    bit          stall_p = 1'b0;
    logic [63:0] p_addr, p_wdata;
    logic [8:0]  p_ctl;

    initial forever begin
        @(negedge clk);
        if (s_rvalid) begin rv_count++; rv_data = s_rdata; rv_cyc = cyc; end
        if (s_valid && s_ready) begin acc_count++; acc_cyc = cyc; end
        if (m_valid) mv_count++;
        if (stall_p && !rst) begin
            chk_eq("m_hold_valid", {63'b0, m_valid}, 64'd1);
            chk_eq("m_hold_addr", m_addr, p_addr);
            chk_eq("m_hold_wdata", m_wdata, p_wdata);
            chk_eq("m_hold_ctl", {55'b0, m_wen, m_wmask}, {55'b0, p_ctl});
        end
        stall_p = m_valid && !m_ready && !rst;
        p_addr = m_addr; p_wdata = m_wdata; p_ctl = {m_wen, m_wmask};
        if (m_valid && m_ready && !rst) begin
            automatic int idx = int'(m_addr[5:3]);
            if (m_wen) begin
                for (int b = 0; b < 8; b++)
                    if (m_wmask[b]) mem[idx][b*8 +: 8] = m_wdata[b*8 +: 8];
                last_wdata = m_wdata;
                last_wmask = m_wmask;
            end
            due_q.push_back(cyc + lat);
            dat_q.push_back(m_wen ? {$urandom, $urandom} : mem[idx]);
        end
    end

    initial begin
        m_rvalid = 1'b0; m_rdata = '0; m_ready = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (due_q.size() > 0 && due_q[0] <= cyc) begin
                m_rvalid = 1'b1;
                m_rdata  = dat_q.pop_front();
                void'(due_q.pop_front());
            end else begin
                m_rvalid = 1'b0;
                m_rdata  = {$urandom, $urandom};
            end
            m_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Reference model: memory image plus reservation, at whole-operation granularity
    logic [63:0] ref_mem [8];
    bit          r_valid = 1'b0;
    logic [63:0] r_dw;

    function automatic logic [63:0] ref_alu(input logic [4:0] op, input bit word,
                                            input logic [63:0] a, input logic [63:0] b);
        logic [63:0] out;
        if (word) begin
            int sa = a[31:0], sb = b[31:0], r;
            int unsigned ua = a[31:0], ub = b[31:0];
            case (op)
                AMO_ADD:  r = sa + sb;
                AMO_SWAP: r = sb;
                AMO_XOR:  r = sa ^ sb;
                AMO_AND:  r = sa & sb;
                AMO_OR:   r = sa | sb;
                AMO_MIN:  r = (sa < sb) ? sa : sb;
                AMO_MAX:  r = (sa > sb) ? sa : sb;
                AMO_MINU: r = (ua < ub) ? sa : sb;
                AMO_MAXU: r = (ua > ub) ? sa : sb;
                default:  r = sa;
            endcase
            out = longint'(r);
        end else begin
            longint sa = a, sb = b;
            longint unsigned ua = a, ub = b;
            case (op)
                AMO_ADD:  out = sa + sb;
                AMO_SWAP: out = sb;
                AMO_XOR:  out = sa ^ sb;
                AMO_AND:  out = sa & sb;
                AMO_OR:   out = sa | sb;
                AMO_MIN:  out = (sa < sb) ? sa : sb;
                AMO_MAX:  out = (sa > sb) ? sa : sb;
                AMO_MINU: out = (ua < ub) ? ua : ub;
                AMO_MAXU: out = (ua > ub) ? ua : ub;
                default:  out = sa;
            endcase
        end
        return out;
    endfunction

    task automatic model_write(input bit word, input logic [63:0] addr, input logic [63:0] v);
        int idx = int'(addr[5:3]);
        if (!word)        ref_mem[idx] = v;
        else if (addr[2]) ref_mem[idx][63:32] = v[31:0];
        else              ref_mem[idx][31:0]  = v[31:0];
        if (r_valid && r_dw == (addr >> 3)) r_valid = 1'b0;
    endtask

    task automatic model(input bit amo, input logic [4:0] op, input bit word, input logic [63:0] addr,
                         input bit wen, input logic [63:0] wdata, input logic [7:0] wmask,
                         output logic [63:0] exp, output bit has_data);
        int          idx = int'(addr[5:3]);
        logic [63:0] old;
        exp = '0;
        has_data = 1'b1;
        if (!amo) begin
            if (wen) begin
                for (int b = 0; b < 8; b++)
                    if (wmask[b]) ref_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
                if (r_valid && r_dw == (addr >> 3)) r_valid = 1'b0;
                has_data = 1'b0;
            end else begin
                exp = ref_mem[idx];
            end
            return;
        end
        old = word ? sext32(addr[2] ? ref_mem[idx][63:32] : ref_mem[idx][31:0]) : ref_mem[idx];
        if (op == AMO_LR) begin
            exp = old; r_valid = 1'b1; r_dw = addr >> 3;
        end else if (op == AMO_SC) begin
            if (r_valid && r_dw == (addr >> 3)) begin
                model_write(word, addr, wdata);
                exp = 64'd0;
            end else begin
                exp = 64'd1;
            end
            r_valid = 1'b0;
        end else begin
            model_write(word, addr, ref_alu(op, word, old, wdata));
            exp = old;
        end
    endtask

    task automatic issue(input bit amo, input logic [4:0] op, input bit word, input logic [63:0] addr,
                         input bit wen, input logic [63:0] wdata, input logic [7:0] wmask,
                         output logic [63:0] rdata, output int resp_lat);
        int a0 = acc_count, r0 = rv_count;
        bit ok = 1'b0;
        @(posedge clk); #1;
        s_valid = 1'b1; s_is_amo = amo; s_amoop = op; s_funct3 = word ? 3'b010 : 3'b011;
        s_addr = addr; s_wen = wen; s_wdata = wdata; s_wmask = wmask;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            if (acc_count != a0) begin ok = 1'b1; break; end
        end
        #1;
        s_valid = 1'b0; s_is_amo = 1'($urandom); s_wdata = {$urandom, $urandom};
        chk_eq("accept", {63'b0, ok}, 64'd1);
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (rv_count != r0) begin ok = 1'b1; break; end
            @(posedge clk);
        end
        chk_eq("response", {63'b0, ok}, 64'd1);
        rdata = rv_data;
        resp_lat = rv_cyc - acc_cyc;
    endtask

    task automatic run_op(input string tag, input bit amo, input logic [4:0] op, input bit word,
                          input logic [63:0] addr, input bit wen, input logic [63:0] wdata,
                          input logic [7:0] wmask, output int resp_lat);
        logic [63:0] rd, exp;
        bit          has_data;
        issue(amo, op, word, addr, wen, wdata, wmask, rd, resp_lat);
        model(amo, op, word, addr, wen, wdata, wmask, exp, has_data);
        if (has_data) chk_eq({tag, "_rdata"}, rd, exp);
        chk_eq({tag, "_mem"}, mem[int'(addr[5:3])], ref_mem[int'(addr[5:3])]);
    endtask

    localparam logic [63:0] BASE = 64'h8000_0000;

    initial begin
        int          l;
        int          r0, m0;
        logic [63:0] rd;
        logic [4:0]  ops [11];
        ops = '{AMO_ADD, AMO_SWAP, AMO_LR, AMO_SC, AMO_XOR, AMO_OR, AMO_AND,
                AMO_MIN, AMO_MAX, AMO_MINU, AMO_MAXU};

        rst = 1'b1;
        s_valid = 1'b0; s_is_amo = 1'b1; s_amoop = '0; s_funct3 = 3'b011;
        s_addr = BASE; s_wen = 1'b0; s_wdata = '0; s_wmask = '0;
        for (int i = 0; i < 8; i++) begin
            mem[i] = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        repeat (3) @(posedge clk);
        #2;
        chk_eq("rst_m_valid", {63'b0, m_valid}, 64'd0);
        chk_eq("rst_s_rvalid", {63'b0, s_rvalid}, 64'd0);
        rst = 1'b0;
        #1;
        chk_eq("idle_s_ready_amo", {63'b0, s_ready}, 64'd1);

        // AMOADD.D: 5 + 7
        mem[2] = 64'd5; ref_mem[2] = 64'd5;
        run_op("add_d", 1, AMO_ADD, 0, BASE + 64'h10, 0, 64'd7, 8'h00, l);
        chk_eq("add_d_lat", 64'(l), 64'd4);
        chk_eq("add_d_wdata", last_wdata, 64'd12);
        chk_eq("add_d_wmask", {56'b0, last_wmask}, 64'hFF);

        // AMOMAX.W / AMOMAXU.W on the upper word
        mem[0][63:32] = 32'hFFFF_FFFF; ref_mem[0] = mem[0];
        run_op("max_w", 1, AMO_MAX, 1, BASE + 64'h4, 0, 64'd3, 8'h00, l);
        chk_eq("max_w_wdata", last_wdata, 64'h0000_0003_0000_0003);
        chk_eq("max_w_wmask", {56'b0, last_wmask}, 64'hF0);
        mem[0][63:32] = 32'hFFFF_FFFF; ref_mem[0] = mem[0];
        run_op("maxu_w", 1, AMO_MAXU, 1, BASE + 64'h4, 0, 64'd3, 8'h00, l);
        chk_eq("maxu_w_wdata", last_wdata, 64'hFFFF_FFFF_FFFF_FFFF);

        // LR/SC pair, then a second SC without reservation
        run_op("lr_d", 1, AMO_LR, 0, BASE + 64'h20, 0, 64'd0, 8'h00, l);
        chk_eq("lr_d_lat", 64'(l), 64'd2);
        run_op("sc_ok", 1, AMO_SC, 0, BASE + 64'h20, 0, 64'hDEAD_BEEF_0123_4567, 8'h00, l);
        chk_eq("sc_ok_lat", 64'(l), 64'd2);
        chk_eq("sc_ok_wdata", last_wdata, 64'hDEAD_BEEF_0123_4567);
        m0 = mv_count;
        run_op("sc_fail", 1, AMO_SC, 0, BASE + 64'h20, 0, 64'h1111, 8'h00, l);
        chk_eq("sc_fail_lat", 64'(l), 64'd1);
        chk_eq("sc_fail_no_bus", 64'(mv_count), 64'(m0));

        // A store into the reserved doubleword kills the reservation
        run_op("lr_d2", 1, AMO_LR, 0, BASE + 64'h20, 0, 64'd0, 8'h00, l);
        run_op("st_24", 0, 5'd0, 0, BASE + 64'h24, 1, 64'h5555_6666_7777_8888, 8'hF0, l);
        run_op("sc_killed", 1, AMO_SC, 0, BASE + 64'h20, 0, 64'h9999, 8'h00, l);

        run_op("ld_18", 0, 5'd0, 0, BASE + 64'h18, 0, 64'd0, 8'h00, l);
        chk_eq("ld_lat", 64'(l), 64'd1);

        // Reset while waiting for read data; the late response must be dropped
        lat = 3;
        begin
            int a0 = acc_count;
            @(posedge clk); #1;
            s_valid = 1'b1; s_is_amo = 1'b1; s_amoop = AMO_ADD; s_funct3 = 3'b011;
            s_addr = BASE + 64'h8; s_wdata = 64'd1;
            for (int t = 0; t < 20 && acc_count == a0; t++) @(posedge clk);
            #1 s_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            r_valid = 1'b0;
            #1;
            chk_eq("midrst_m_valid", {63'b0, m_valid}, 64'd0);
            @(posedge clk); #1;
            rst = 1'b0;
            r0 = rv_count;
            repeat (6) @(posedge clk);
            chk_eq("midrst_no_rvalid", 64'(rv_count), 64'(r0));
            chk_eq("midrst_mem", mem[1], ref_mem[1]);
        end
        lat = 1;
        run_op("ld_after_rst", 0, 5'd0, 0, BASE, 0, 64'd0, 8'h00, l);
        chk_eq("ld_after_rst_lat", 64'(l), 64'd1);

        // Random traffic with back-pressure and variable response latency
        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            int          kind = $urandom_range(0, 12);
            bit          word = 1'($urandom);
            logic [63:0] addr = BASE + 64'($urandom_range(0, 3) * 8);
            lat = $urandom_range(1, 3);
            if (kind < 11) begin
                if (word) addr = addr + 64'($urandom_range(0, 1) * 4);
                run_op("rand_amo", 1, ops[kind], word, addr, 0, {$urandom, $urandom}, 8'($urandom), l);
            end else begin
                run_op("rand_plain", 0, 5'd0, 0, addr, kind == 12, {$urandom, $urandom}, 8'($urandom), l);
            end
        end

        repeat (5) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
